// File: rtl/mc_cu.sv
//=============================================================================
// Module      : mc_cu
// Description : Multi-cycle control unit for the MIPS-subset CPU. A single
//               state register sequences IF/ID/EXE/MEM/WB. Every other
//               output is a combinational decode of state, op, func, z and
//               mem_ready.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
// Optional feature macro: MC_CU_ILLEGAL_TRAP_EN
//   defined   : adds output 'illegal'. An undefined instruction in ID pulses
//               illegal and parks the FSM in HALT until resetn is asserted.
//   undefined : an undefined instruction executes as a two-cycle nop.
//-----------------------------------------------------------------------------
// Ports:
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   op         in   IR[31:26]
//   func       in   IR[5:0]
//   z          in   ALU zero flag (used in EXE only)
//   mem_ready  in   memory access done this cycle (used in IF and MEM only)
//   wpc/wir/wmem/wreg out  write strobes, forced low while resetn=0
//   iord       out  memory address select: 0=PC, 1=ALU result register
//   regrt      out  destination select: 1=rt, 0=rd
//   m2reg      out  writeback select: 1=memory data
//   jal        out  writeback PC+4 to jal_rd
//   jal_rd     out  constant JAL_REG
//   sext       out  sign-extend immediate
//   shift      out  ALU A = sa
//   alusrca    out  ALU A: 0=PC, 1=register/sa
//   alusrcb    out  ALU B: 00=reg, 01=4, 10=ext imm, 11=ext imm<<2
//   aluc       out  ALU operation
//   pcsource   out  00=ALU, 01=branch target reg, 10=rs, 11=jump address
//   state      out  IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5
//   illegal    out  (MC_CU_ILLEGAL_TRAP_EN only) undefined-instruction pulse
//=============================================================================
`default_nettype none

module mc_cu #(
   parameter logic [4:0] JAL_REG = 5'd31
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       z,
   input  logic       mem_ready,
   output logic       wpc,
   output logic       wir,
   output logic       iord,
   output logic       wmem,
   output logic       wreg,
   output logic       regrt,
   output logic       m2reg,
   output logic       jal,
   output logic [4:0] jal_rd,
   output logic       sext,
   output logic       shift,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [3:0] aluc,
   output logic [1:0] pcsource,
   output logic [2:0] state
`ifdef MC_CU_ILLEGAL_TRAP_EN
   ,
   output logic       illegal
`endif
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
`ifdef MC_CU_ILLEGAL_TRAP_EN
      S_HALT = 3'd5,
`endif
      S_WB   = 3'd4
   } state_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   state_e state_q, state_d;

   // Ungated write strobes; the port versions are qualified by resetn.
   logic wpc_c, wir_c, wmem_c, wreg_c;

   //--------------------------------------------------------------------------
   // Instruction decode
   //--------------------------------------------------------------------------
   logic rtype;
   logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
   logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw;
   logic i_beq, i_bne, i_j, i_jal;
   logic is_shift, is_ralu, is_ialu, is_valid, use_sext;
   logic [3:0] alu_fn;

   assign rtype  = (op == 6'b000000);
   assign i_add  = rtype & (func == 6'b100000);
   assign i_sub  = rtype & (func == 6'b100010);
   assign i_and  = rtype & (func == 6'b100100);
   assign i_or   = rtype & (func == 6'b100101);
   assign i_xor  = rtype & (func == 6'b100110);
   assign i_sll  = rtype & (func == 6'b000000);
   assign i_srl  = rtype & (func == 6'b000010);
   assign i_sra  = rtype & (func == 6'b000011);
   assign i_jr   = rtype & (func == 6'b001000);
   assign i_addi = (op == 6'b001000);
   assign i_andi = (op == 6'b001100);
   assign i_ori  = (op == 6'b001101);
   assign i_xori = (op == 6'b001110);
   assign i_lui  = (op == 6'b001111);
   assign i_lw   = (op == 6'b100011);
   assign i_sw   = (op == 6'b101011);
   assign i_beq  = (op == 6'b000100);
   assign i_bne  = (op == 6'b000101);
   assign i_j    = (op == 6'b000010);
   assign i_jal  = (op == 6'b000011);

   assign is_shift = i_sll | i_srl | i_sra;
   assign is_ralu  = i_add | i_sub | i_and | i_or | i_xor | is_shift;
   assign is_ialu  = i_addi | i_andi | i_ori | i_xori | i_lui;
   assign is_valid = is_ralu | i_jr | is_ialu | i_lw | i_sw |
                     i_beq | i_bne | i_j | i_jal;
   assign use_sext = i_addi | i_lw | i_sw | i_beq | i_bne;

   // ALU function for the EXE cycle; loads/stores fall through to add.
   always_comb begin
      alu_fn = ALU_ADD;
      if (i_sub | i_beq | i_bne)  alu_fn = ALU_SUB;
      else if (i_and | i_andi)    alu_fn = ALU_AND;
      else if (i_or  | i_ori)     alu_fn = ALU_OR;
      else if (i_xor | i_xori)    alu_fn = ALU_XOR;
      else if (i_lui)             alu_fn = ALU_LUI;
      else if (i_sll)             alu_fn = ALU_SLL;
      else if (i_srl)             alu_fn = ALU_SRL;
      else if (i_sra)             alu_fn = ALU_SRA;
   end

   //--------------------------------------------------------------------------
   // State register
   //--------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   //--------------------------------------------------------------------------
   // Next state and output decode
   //--------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      wpc_c    = 1'b0;
      wir_c    = 1'b0;
      wmem_c   = 1'b0;
      wreg_c   = 1'b0;
      iord     = 1'b0;
      regrt    = 1'b0;
      m2reg    = 1'b0;
      jal      = 1'b0;
      sext     = 1'b0;
      shift    = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluc     = ALU_ADD;
      pcsource = 2'b00;
`ifdef MC_CU_ILLEGAL_TRAP_EN
      illegal  = 1'b0;
`endif
      case (state_q)
         S_IF: begin
            // PC+4 computed every cycle; committed only when the fetch lands.
            alusrcb = 2'b01;
            if (mem_ready) begin
               wir_c   = 1'b1;
               wpc_c   = 1'b1;
               state_d = S_ID;
            end
         end
         S_ID: begin
            // ALU forms the branch target; the datapath captures it.
            alusrcb = 2'b11;
            sext    = use_sext;
            if (i_j | i_jal) begin
               wpc_c    = 1'b1;
               pcsource = 2'b11;
               wreg_c   = i_jal;
               jal      = i_jal;
               state_d  = S_IF;
            end else if (i_jr) begin
               wpc_c    = 1'b1;
               pcsource = 2'b10;
               state_d  = S_IF;
            end else if (is_valid) begin
               state_d  = S_EXE;
            end else begin
`ifdef MC_CU_ILLEGAL_TRAP_EN
               illegal  = 1'b1;
               state_d  = S_HALT;
`else
               state_d  = S_IF;
`endif
            end
         end
         S_EXE: begin
            sext = use_sext;
            aluc = alu_fn;
            if (is_ralu) begin
               alusrca = 1'b1;
               shift   = is_shift;
               state_d = S_WB;
            end else if (is_ialu) begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
               state_d = S_WB;
            end else if (i_lw | i_sw) begin
               alusrcb = 2'b10;
               state_d = S_MEM;
            end else begin
               // Branches: compare rs/rt, redirect PC to the ID-stage target.
               alusrca = 1'b1;
               if ((i_beq & z) | (i_bne & ~z)) begin
                  wpc_c    = 1'b1;
                  pcsource = 2'b01;
               end
               state_d = S_IF;
            end
         end
         S_MEM: begin
            iord   = 1'b1;
            wmem_c = i_sw;
            if (mem_ready) begin
               state_d = i_lw ? S_WB : S_IF;
            end
         end
         S_WB: begin
            wreg_c  = 1'b1;
            m2reg   = i_lw;
            regrt   = is_ialu | i_lw;
            state_d = S_IF;
         end
`ifdef MC_CU_ILLEGAL_TRAP_EN
         S_HALT: begin
            state_d = S_HALT;
         end
`endif
         default: begin
            state_d = S_IF;
         end
      endcase
   end

   // Strobes are qualified by resetn so nothing is written while reset is low,
   // including the cycle on which it falls.
   assign wpc    = wpc_c  & resetn;
   assign wir    = wir_c  & resetn;
   assign wmem   = wmem_c & resetn;
   assign wreg   = wreg_c & resetn;
   assign jal_rd = JAL_REG;
   assign state  = state_q;

endmodule

`default_nettype wire

// File: doc/mc_cu.md
Name: mc_cu

Overview:
- Multi-cycle control unit for the MIPS-subset CPU; replaces the single-cycle decoder when the datapath shares one memory and one ALU across cycles.
- FSM sequences IF/ID/EXE/MEM/WB; drives PC/IR/regfile/memory write strobes and datapath mux selects.
- Handshakes with memory through mem_ready.
- op/func come from the external IR (loaded by wir); z from the ALU.

Parameters:
- JAL_REG, 5'd31, destination register number for jal; exported via jal_rd.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- z  in  1  ALU zero flag, valid in EXE
- mem_ready  in  1  memory access done this cycle
- wpc  out  1  PC write enable
- wir  out  1  IR write enable
- iord  out  1  memory address select: 0=PC, 1=ALU result register
- wmem  out  1  memory write request
- wreg  out  1  register file write enable
- regrt  out  1  destination select: 1=rt, 0=rd
- m2reg  out  1  writeback select: 1=memory data
- jal  out  1  writeback PC+4 to jal_rd
- jal_rd  out  5  constant JAL_REG
- sext  out  1  sign-extend immediate
- shift  out  1  ALU A = sa
- alusrca  out  1  ALU A: 0=PC, 1=register/sa
- alusrcb  out  2  ALU B: 00=reg, 01=const 4, 10=ext imm, 11=ext imm<<2
- aluc  out  4  ALU op
- pcsource  out  2  00=ALU, 01=branch-target register, 10=rs (jr), 11=jump address
- state  out  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5

Behaviour:
- State register is the only storage. All other outputs are combinational decodes of state, op, func, z and mem_ready.
- Reset: resetn=0 forces state=IF asynchronously. All write strobes (wpc, wir, wmem, wreg) are ANDed with resetn, so they are 0 during reset. Selects may take their IF values during reset.
- Decode set: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal. Opcodes/func values as in the single-cycle CU.
- aluc encoding:
  - add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
  - addi/lw/sw use add; beq/bne use sub.
- sext=1 for addi, lw, sw, beq, bne; 0 for andi, ori, xori, lui.
- Output defaults: every output not listed for a state is 0.
- IF:
  - iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - If mem_ready: wir=1, wpc=1, next=ID. Otherwise stay in IF with wir=wpc=0 (any number of wait cycles).
- ID:
  - alusrca=0, alusrcb=11, aluc=add (branch target captured externally).
  - j: wpc=1, pcsource=11.
  - jal: wpc=1, pcsource=11, wreg=1, jal=1.
  - jr: wpc=1, pcsource=10.
  - After j/jal/jr, next=IF. Other valid instructions go to EXE. Undefined instruction: see Optional Feature.
- EXE:
  - R-type: alusrca=1, alusrcb=00, shift for sll/srl/sra. next=WB.
  - I-ALU ops: alusrca=1, alusrcb=10. next=WB.
  - lw/sw: alusrcb=10, aluc=add. next=MEM.
  - beq/bne: alusrca=1, alusrcb=00, aluc=sub. Taken (beq&z, bne&~z) gives wpc=1, pcsource=01. next=IF regardless of outcome.
- MEM:
  - iord=1. sw: wmem=1, held until mem_ready. lw: wait for mem_ready.
  - On mem_ready: sw goes to IF, lw goes to WB. No timeout.
- WB:
  - wreg=1. m2reg=1 for lw. regrt=1 for I-type and lw. next=IF.
- Latency with mem_ready tied 1: j/jr/jal 2 cycles; beq/bne 3; R/I-ALU 4; sw 4; lw 5. Each memory wait cycle adds one.
- Reset mid-instruction: aborts immediately. No strobe is asserted on the cycle resetn falls. Execution resumes at IF.
- z and mem_ready are ignored outside EXE and IF/MEM respectively.

Optional Feature:
- Macro MC_CU_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port illegal (1 bit).
  - An undefined op/func in ID pulses illegal=1 for that cycle and moves to HALT.
  - HALT asserts no strobes and stays until resetn=0.
- Undefined:
  - No port, no HALT state.
  - An undefined instruction in ID behaves as a nop: no strobes, next=IF, 2 cycles.

Test Plan:
- Reset released, mem_ready=1, IR=add (op 000000, func 100000) -> state IF,ID,EXE,WB; wreg=1 only in WB with regrt=0; wir=wpc=1 only in IF.
- lw (op 100011) with mem_ready low 2 cycles in MEM -> 7 cycles total; iord=1 for 3 MEM cycles; wreg&m2reg in WB.
- beq (op 000100), z=1 -> wpc=1, pcsource=01 in EXE; repeat with z=0 -> wpc=0; both return to IF after 3 cycles.
- jal (op 000011) -> ID asserts wpc, pcsource=11, wreg, jal, jal_rd=31; next state IF.
- resetn pulsed low mid-MEM of sw with wmem=1 -> wmem drops to 0 asynchronously; state=0; first post-reset cycle is IF.
- op 111111: with MC_CU_ILLEGAL_TRAP_EN, illegal pulses 1 cycle and state=5 persists; without it, nop, next state IF.
